// File: rtl/sweep_pkg.sv
// Shared definitions for the up/down sweep sequencer.
//   ST_*     : 3-bit controller state encoding (visible on dbg_state).
//   MODE_*   : counter direction encoding, identical to up_down_counter
//              (0 = count up, 1 = count down).
//   state_t  : controller FSM state type built on the ST_* codes.
package sweep_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_UP   = 3'd2;
  localparam logic [2:0] ST_DOWN = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_UP   = ST_UP,
    S_DOWN = ST_DOWN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/updown_cnt_core.sv
// N-bit up/down counter register driven by the sweep controller.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : count <= load_val (has priority over en)
//   load_val  : value loaded when load is high
//   en        : step the counter by one in direction mode
//   mode      : MODE_UP (0) increments, MODE_DOWN (1) decrements
//   count     : current counter value
module updown_cnt_core
  import sweep_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         mode,
  output logic [N-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= (mode == MODE_DOWN) ? count - 1'b1 : count + 1'b1;
    end
  end

  // The controller turns around at the latched bounds, so a step must never
  // carry past either end of the counter range.
  a_no_wrap: assert property (@(posedge clk) disable iff (rst)
    (en && !load) |-> ((mode == MODE_UP) ? (count != {N{1'b1}}) : (count != '0)));

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer that runs the up/down counter through num_sweeps triangular
// sweeps lo -> hi -> lo after an accepted start pulse.
// Optional feature: define SWEEP_CFG_ERR_EN to add the cfg_err output,
// a one-cycle pulse the cycle after a start is rejected in IDLE.
// Handshake: start is a single-cycle request sampled only in IDLE; it is
// accepted when lo < hi and num_sweeps != 0. abort ends a run from
// LOAD/UP/DOWN without a done pulse. No back-pressure exists.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : run request (IDLE only)
//   abort       : terminate a run (ignored in IDLE/DONE)
//   lo, hi      : sweep bounds, latched on accepted start
//   num_sweeps  : number of lo->hi->lo sweeps, latched on accepted start
//   mode        : direction currently applied, 0 = up, 1 = down
//   count       : counter value
//   sweep_idx   : completed sweeps in the current run
//   busy        : high in LOAD/UP/DOWN
//   done        : one-cycle pulse after the final sweep
//   dbg_state   : controller state (ST_* codes)
//   cfg_err     : (SWEEP_CFG_ERR_EN only) rejected-start pulse
module updown_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  lo,
  input  logic [N-1:0]  hi,
  input  logic [SW-1:0] num_sweeps,
  output logic          mode,
  output logic [N-1:0]  count,
  output logic [SW-1:0] sweep_idx,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
`ifdef SWEEP_CFG_ERR_EN
  ,
  output logic          cfg_err
`endif
);

  state_t        state;
  logic [N-1:0]  lo_q;
  logic [N-1:0]  hi_q;
  logic [SW-1:0] num_q;

  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_dir;
  logic          start_ok;
  logic          last_sweep;

  assign start_ok   = (lo < hi) && (num_sweeps != '0);
  assign last_sweep = ((sweep_idx + 1'b1) == num_q);
  assign dbg_state  = state;

  // Counter controls for the step taken at the coming edge. The direction
  // here is the step direction, which flips in the same cycle the bound is
  // seen; the registered mode output follows one edge later with the count.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_dir  = MODE_UP;
    if (!abort) begin
      case (state)
        S_LOAD: cnt_load = 1'b1;
        S_UP: begin
          cnt_en  = 1'b1;
          cnt_dir = (count == hi_q) ? MODE_DOWN : MODE_UP;
        end
        S_DOWN: begin
          if (count != lo_q) begin
            cnt_en  = 1'b1;
            cnt_dir = MODE_DOWN;
          end else if (!last_sweep) begin
            cnt_en  = 1'b1;
            cnt_dir = MODE_UP;
          end
        end
        default: ;
      endcase
    end
  end

  updown_cnt_core #(.N(N)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (lo_q),
    .en       (cnt_en),
    .mode     (cnt_dir),
    .count    (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      num_q     <= '0;
      sweep_idx <= '0;
      mode      <= MODE_UP;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SWEEP_CFG_ERR_EN
      cfg_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SWEEP_CFG_ERR_EN
      cfg_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              lo_q      <= lo;
              hi_q      <= hi;
              num_q     <= num_sweeps;
              sweep_idx <= '0;
              busy      <= 1'b1;
              state     <= S_LOAD;
            end else begin
`ifdef SWEEP_CFG_ERR_EN
              cfg_err <= 1'b1;
`endif
            end
          end
        end
        S_LOAD, S_UP, S_DOWN: begin
          if (abort) begin
            busy  <= 1'b0;
            mode  <= MODE_UP;
            state <= S_IDLE;
          end else if (state == S_LOAD) begin
            mode  <= MODE_UP;
            state <= S_UP;
          end else if (state == S_UP) begin
            if (count == hi_q) begin
              mode  <= MODE_DOWN;
              state <= S_DOWN;
            end
          end else if (count == lo_q) begin
            sweep_idx <= sweep_idx + 1'b1;
            mode      <= MODE_UP;
            if (last_sweep) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_UP;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
